reg_file_sequencer: RTL and testbench

- Initiator for the 8x8 register file interface.
- Accepts one 32-bit instruction per valid/ready handshake and decodes it.
- Drives the read addresses, waits out the register file read latency, computes the result in an internal 8-bit ALU, and issues a one-cycle write.
- Sits between instruction fetch and the register file in the simple processor.

---
 rtl/reg_file_sequencer_if.sv | 28 ++
 rtl/reg_file_sequencer.sv | 170 +++++++++++++++++
 tb/tb_reg_file_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/reg_file_sequencer_if.sv
// Instruction handshake plus register-file read/write bus for reg_file_sequencer.
// master = sequencer side, slave = fetch/register-file side.
interface reg_file_sequencer_if;
    logic [31:0] INSTR;
    logic        INSTR_VALID;
    logic        INSTR_READY;
    logic [7:0]  REGOUT1;
    logic [7:0]  REGOUT2;
    logic [2:0]  READREG1;
    logic [2:0]  READREG2;
    logic [2:0]  WRITEREG;
    logic [7:0]  WRITEDATA;
    logic        WRITEENABLE;
    logic        BUSY;
    logic        ILLEGAL;

    modport master (
        input  INSTR, INSTR_VALID, REGOUT1, REGOUT2,
        output INSTR_READY, READREG1, READREG2, WRITEREG, WRITEDATA,
        output WRITEENABLE, BUSY, ILLEGAL
    );

    modport slave (
        output INSTR, INSTR_VALID, REGOUT1, REGOUT2,
        input  INSTR_READY, READREG1, READREG2, WRITEREG, WRITEDATA,
        input  WRITEENABLE, BUSY, ILLEGAL
    );
endinterface

// File: rtl/reg_file_sequencer.sv
// Decodes one instruction at a time, reads the 8x8 register file, runs an 8-bit ALU, writes back.
// Optional FORWARD_EN: reuse the last written result and skip READ when all sources match it.
module reg_file_sequencer #(
    parameter int READ_WAIT = 1,
    parameter int OPCODE_W  = 8
) (
    input logic                  CLK,
    input logic                  RESET,
    reg_file_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

    localparam logic [OPCODE_W-1:0] OP_LOADI = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_MOV   = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_SUB   = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_AND   = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_OR    = OPCODE_W'(5);
    localparam logic [3:0]          RW_LAST  = 4'(READ_WAIT - 1);

    state_t              state, state_n;
    logic [OPCODE_W-1:0] opc_q, opc_n;
    logic [7:0]          imm_q, imm_n;
    logic [7:0]          op1_q, op1_n, op2_q, op2_n;
    logic [3:0]          cnt_q, cnt_n;
    logic [2:0]          rr1_q, rr1_n, rr2_q, rr2_n, wr_q, wr_n;
    logic [7:0]          wd_q, wd_n;
    logic                we_q, we_n, ill_q, ill_n;
    logic                rdy_q, busy_q;
    logic [7:0]          alu;
    logic                fwd_hit;
    logic [7:0]          fwd_data;

    wire [OPCODE_W-1:0] opc_in = bus.INSTR[31 -: OPCODE_W];
    wire [2:0]          dst_in = bus.INSTR[18:16];
    wire [2:0]          s1_in  = bus.INSTR[10:8];
    wire [2:0]          s2_in  = bus.INSTR[2:0];
    wire                legal_in = (opc_in <= OP_OR);
    wire                unused_fields = ^{bus.INSTR[23:19], bus.INSTR[15:11]};

`ifdef FORWARD_EN
    logic [2:0] last_dest;
    logic [7:0] last_result;
    logic       last_valid;

    // loadi refreshes the cached value but leaves LAST_VALID as it was
    always_ff @(posedge CLK) begin
        if (RESET) begin
            last_dest   <= '0;
            last_result <= '0;
            last_valid  <= 1'b0;
        end else if (state == WRITE) begin
            last_dest   <= wr_q;
            last_result <= wd_q;
            if (opc_q != OP_LOADI) last_valid <= 1'b1;
        end
    end

    assign fwd_hit  = last_valid && ((opc_in == OP_MOV) ? (s2_in == last_dest)
                                     : (s1_in == last_dest) && (s2_in == last_dest));
    assign fwd_data = last_result;
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    always_comb begin
        alu = '0;
        case (opc_q)
            OP_LOADI: alu = imm_q;
            OP_MOV:   alu = op2_q;
            OP_ADD:   alu = op1_q + op2_q;
            OP_SUB:   alu = op1_q - op2_q;
            OP_AND:   alu = op1_q & op2_q;
            OP_OR:    alu = op1_q | op2_q;
            default:  alu = '0;
        endcase
    end

    always_comb begin
        state_n = state;
        opc_n   = opc_q;
        imm_n   = imm_q;
        op1_n   = op1_q;
        op2_n   = op2_q;
        cnt_n   = cnt_q;
        rr1_n   = rr1_q;
        rr2_n   = rr2_q;
        wr_n    = wr_q;
        wd_n    = wd_q;
        we_n    = 1'b0;
        ill_n   = 1'b0;
        case (state)
            IDLE: if (bus.INSTR_VALID) begin
                opc_n = opc_in;
                imm_n = bus.INSTR[7:0];
                rr1_n = s1_in;
                rr2_n = s2_in;
                wr_n  = dst_in;
                cnt_n = '0;
                if (!legal_in)
                    ill_n = 1'b1;
                else if (opc_in == OP_LOADI)
                    state_n = EXEC;
                else if (fwd_hit) begin
                    op1_n   = fwd_data;
                    op2_n   = fwd_data;
                    state_n = EXEC;
                end else
                    state_n = READ;
            end
            READ: if (cnt_q == RW_LAST) begin
                op1_n   = bus.REGOUT1;
                op2_n   = bus.REGOUT2;
                state_n = EXEC;
            end else
                cnt_n = cnt_q + 4'd1;
            EXEC: begin
                wd_n    = alu;
                we_n    = 1'b1;
                state_n = WRITE;
            end
            WRITE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= IDLE;
            opc_q  <= '0;
            imm_q  <= '0;
            op1_q  <= '0;
            op2_q  <= '0;
            cnt_q  <= '0;
            rr1_q  <= '0;
            rr2_q  <= '0;
            wr_q   <= '0;
            wd_q   <= '0;
            we_q   <= 1'b0;
            ill_q  <= 1'b0;
            busy_q <= 1'b0;
            rdy_q  <= 1'b1;
        end else begin
            state  <= state_n;
            opc_q  <= opc_n;
            imm_q  <= imm_n;
            op1_q  <= op1_n;
            op2_q  <= op2_n;
            cnt_q  <= cnt_n;
            rr1_q  <= rr1_n;
            rr2_q  <= rr2_n;
            wr_q   <= wr_n;
            wd_q   <= wd_n;
            we_q   <= we_n;
            ill_q  <= ill_n;
            busy_q <= (state_n != IDLE);
            rdy_q  <= (state_n == IDLE);
        end
    end

    assign bus.INSTR_READY = rdy_q;
    assign bus.BUSY        = busy_q;
    assign bus.READREG1    = rr1_q;
    assign bus.READREG2    = rr2_q;
    assign bus.WRITEREG    = wr_q;
    assign bus.WRITEDATA   = wd_q;
    assign bus.WRITEENABLE = we_q;
    assign bus.ILLEGAL     = ill_q;
endmodule

// File: tb/tb_reg_file_sequencer.sv
// Randomized bench for reg_file_sequencer: register file model plus an instruction-level reference.
module tb_reg_file_sequencer;
    localparam int RW = 1;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    reg_file_sequencer_if bus();
    reg_file_sequencer #(.READ_WAIT(RW), .OPCODE_W(8)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

    // register file seen by the DUT, and the architectural state the reference expects
    logic [7:0] rf [8];
    logic [7:0] mdl [8];
    assign bus.REGOUT1 = rf[bus.READREG1];
    assign bus.REGOUT2 = rf[bus.READREG2];
    always @(posedge CLK) if (bus.WRITEENABLE) rf[bus.WRITEREG] <= bus.WRITEDATA;

    bit         fv = 1'b0;
    logic [2:0] fd = '0;
    logic [7:0] fr = '0;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one instruction and check its whole life against the reference.
    task automatic issue(input logic [31:0] ins, input bit hold, input logic [31:0] nxt);
        logic [7:0] opc, x, y, res;
        logic [2:0] d, a, b;
        bit         skip;
        int         n, k, exp_lat;
        opc = ins[31:24]; d = ins[18:16]; a = ins[10:8]; b = ins[2:0];
        n = 0;
        while (!bus.INSTR_READY && n < 50) begin @(negedge CLK); n++; end
        if (!bus.INSTR_READY) begin chk("ready_timeout", 0, 1); return; end
        bus.INSTR = ins; bus.INSTR_VALID = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        if (hold && opc <= 8'd5) bus.INSTR = nxt;
        else bus.INSTR_VALID = 1'b0;
        chk("readreg1", bus.READREG1, a);
        chk("readreg2", bus.READREG2, b);
        chk("writereg_acc", bus.WRITEREG, d);
        if (opc > 8'd5) begin
            chk("illegal_pulse", bus.ILLEGAL, 1);
            chk("illegal_we", bus.WRITEENABLE, 0);
            chk("illegal_ready", bus.INSTR_READY, 1);
            chk("illegal_busy", bus.BUSY, 0);
            @(negedge CLK);
            chk("illegal_end", bus.ILLEGAL, 0);
            chk("illegal_we2", bus.WRITEENABLE, 0);
            return;
        end
        x = mdl[a]; y = mdl[b];
        skip = 1'b0;
`ifdef FORWARD_EN
        if (opc != 8'd0 && fv && ((opc == 8'd1) ? (b == fd) : (a == fd && b == fd))) begin
            skip = 1'b1; x = fr; y = fr;
        end
`endif
        case (opc)
            8'd0: res = ins[7:0];
            8'd1: res = y;
            8'd2: res = 8'((int'(x) + int'(y)) % 256);
            8'd3: res = 8'((int'(x) - int'(y) + 256) % 256);
            8'd4: res = x & y;
            default: res = x | y;
        endcase
        chk("busy_acc", bus.BUSY, 1);
        chk("ready_acc", bus.INSTR_READY, 0);
        exp_lat = (opc == 8'd0 || skip) ? 1 : RW + 1;
        k = 0;
        while (!bus.WRITEENABLE && k < 40) begin @(negedge CLK); k++; end
        chk("we_latency", k, exp_lat);
        chk("writedata", bus.WRITEDATA, res);
        chk("writereg", bus.WRITEREG, d);
        chk("addr_hold1", bus.READREG1, a);
        chk("addr_hold2", bus.READREG2, b);
        chk("ready_in_write", bus.INSTR_READY, 0);
        @(negedge CLK);
        chk("we_one_cycle", bus.WRITEENABLE, 0);
        chk("ready_after", bus.INSTR_READY, 1);
        chk("busy_after", bus.BUSY, 0);
        chk("data_hold", bus.WRITEDATA, res);
        mdl[d] = res;
        fd = d; fr = res;
        if (opc != 8'd0) fv = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [31:0] seq [80];
    bit          hl  [80];

    initial begin
        logic [2:0] ld;
        logic [7:0] op;
        RESET = 1'b1; bus.INSTR_VALID = 1'b1; bus.INSTR = 32'h00020005;
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_ready", bus.INSTR_READY, 1);
        chk("rst_busy", bus.BUSY, 0);
        chk("rst_we", bus.WRITEENABLE, 0);
        chk("rst_ill", bus.ILLEGAL, 0);
        chk("rst_rr1", bus.READREG1, 0);
        chk("rst_rr2", bus.READREG2, 0);
        chk("rst_wr", bus.WRITEREG, 0);
        chk("rst_wd", bus.WRITEDATA, 0);
        bus.INSTR_VALID = 1'b0; RESET = 1'b0;

        // seed every register with a random value
        for (int r = 0; r < 8; r++) issue({8'h00, 5'($urandom), 3'(r), 8'($urandom), 8'($urandom)}, 0, 0);

        issue(32'h00020005, 0, 0);
        issue(32'h000100F0, 0, 0);
        issue(32'h00020020, 0, 0);
        issue(32'h02030102, 0, 0);
        chk("add_wrap_model", mdl[3], 8'h10);
        issue(32'h07000000, 0, 0);
        issue(32'h03040201, 1, 32'h02050403);
        issue(32'h02050403, 0, 0);

        // reset while an add sits in READ: no write may follow
        @(negedge CLK);
        bus.INSTR = 32'h02060102; bus.INSTR_VALID = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        bus.INSTR_VALID = 1'b0; RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        chk("midrst_we", bus.WRITEENABLE, 0);
        chk("midrst_ready", bus.INSTR_READY, 1);
        chk("midrst_busy", bus.BUSY, 0);
        chk("midrst_rr1", bus.READREG1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("midrst_no_we", bus.WRITEENABLE, 0);
        end
        fv = 1'b0;

        // reg op, then loadi r4,6 then mov r5,r4
        issue(32'h04060101, 0, 0);
        issue(32'h00040006, 0, 0);
        issue(32'h01050004, 0, 0);
        chk("mov_fwd_model", mdl[5], 8'h06);

        ld = 3'd5;
        for (int i = 0; i < 80; i++) begin
            op = 8'($urandom_range(0, 6));
            if (op == 8'd6) op = 8'($urandom_range(6, 255));
            seq[i] = {op, 8'($urandom), 8'($urandom), 8'($urandom)};
            if (op != 8'd0 && $urandom_range(0, 3) == 0) begin
                seq[i][10:8] = ld;
                seq[i][2:0]  = ld;
            end
            if (op <= 8'd5) ld = seq[i][18:16];
            hl[i] = ($urandom_range(0, 1) == 1);
        end
        for (int i = 0; i < 80; i++)
            issue(seq[i], hl[i] && i < 79, (i < 79) ? seq[(i < 79) ? i + 1 : i] : 32'h0);

        @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
